// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic grid: accumulate modes, lane slicing
// and the width helper used for the fill counter.
package systolic_pkg;

  localparam int ACC_PASS = 0;
  localparam int ACC_SAT  = 1;

  // Low bit index of lane `lane` in a packed bus of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/systolic_if.sv
// Streaming bus of the systolic grid: per-lane data in/out, valid tracking
// and fill status. The grid is the slave; whoever feeds it is the master.
interface systolic_if
  import systolic_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int W    = 8
);

  localparam int CW = clog2(ROWS + 1);

  // Handshake: enable advances every pipeline; in_valid only marks whether the
  // lanes presented on an enabled cycle carry data. There is no back-pressure.
  logic                enable;
  logic                clear;
  logic                set;
  logic [COLS*W-1:0]   a_in;
  logic [COLS*W-1:0]   b_in;
  logic                in_valid;
  logic [COLS*W-1:0]   a_out;
  logic [COLS*W-1:0]   b_out;
  logic                out_valid;
  logic [CW-1:0]       fill_count;
  logic                primed;

  modport master (
    output enable, clear, set, a_in, b_in, in_valid,
    input  a_out, b_out, out_valid, fill_count, primed
  );

  modport slave (
    input  enable, clear, set, a_in, b_in, in_valid,
    output a_out, b_out, out_valid, fill_count, primed
  );

endinterface

// File: rtl/systolic_cell.sv
// One grid cell: a vertically shifting register and a diagonal b register
// that either passes its diagonal input or accumulates a into it with saturation.
module systolic_cell
  import systolic_pkg::*;
#(
  parameter int W        = 8,
  parameter int ACC_MODE = ACC_PASS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic         set,
  input  logic [W-1:0] a_src,
  input  logic [W-1:0] diag,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q
);

  logic [W:0]   sum;
  logic [W-1:0] b_next;

  // The add is one bit wider than a lane so the carry out is the clamp flag.
  always_comb begin
    sum    = {1'b0, diag} + {1'b0, a_src};
    b_next = diag;
    if (ACC_MODE == ACC_SAT) begin
      b_next = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q <= '0;
    end else if (enable) begin
      a_q <= a_src;
    end
  end

  // clear beats set beats enable; a never sees clear or set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_q <= '0;
    end else if (clear) begin
      b_q <= '0;
    end else if (set) begin
      b_q <= {W{1'b1}};
    end else if (enable) begin
      b_q <= b_next;
    end
  end

endmodule

// File: rtl/systolic_grid.sv
// ROWS x COLS systolic fabric: a shifts straight down, b moves down-right,
// with a valid pipeline and a fill counter that reports when the grid is primed.
module systolic_grid
  import systolic_pkg::*;
#(
  parameter int ROWS     = 5,
  parameter int COLS     = 5,
  parameter int W        = 8,
  parameter int ACC_MODE = ACC_PASS
) (
  input  logic     clock,
  input  logic     reset,
  systolic_if.slave bus
);

  localparam int            CW       = clog2(ROWS + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(ROWS);

  logic [W-1:0]    a_q [ROWS][COLS];
  logic [W-1:0]    b_q [ROWS][COLS];
  logic [ROWS-1:0] valid_q;
  logic [CW-1:0]   fill_q;
  logic            primed_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [W-1:0] a_src;
      logic [W-1:0] diag;

      if (r == 0) begin : g_top
        assign a_src = bus.a_in[lane_lo(c, W) +: W];
        assign diag  = bus.b_in[lane_lo(c, W) +: W];
      end else begin : g_inner
        assign a_src = a_q[r-1][c];
        // Column 0 has no up-left neighbour, so its diagonal feed is zero.
        if (c == 0) begin : g_edge
          assign diag = '0;
        end else begin : g_diag
          assign diag = b_q[r-1][c-1];
        end
      end

      systolic_cell #(
        .W        (W),
        .ACC_MODE (ACC_MODE)
      ) u_cell (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .clear  (bus.clear),
        .set    (bus.set),
        .a_src  (a_src),
        .diag   (diag),
        .a_q    (a_q[r][c]),
        .b_q    (b_q[r][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign bus.a_out[lane_lo(c, W) +: W] = a_q[ROWS-1][c];
    assign bus.b_out[lane_lo(c, W) +: W] = b_q[ROWS-1][c];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (bus.clear) begin
      valid_q <= '0;
    end else if (bus.enable) begin
      valid_q[0] <= bus.in_valid;
      for (int i = 1; i < ROWS; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // primed is registered alongside the count so it rises on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else if (bus.clear) begin
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else if (bus.enable && (fill_q != FILL_MAX)) begin
      fill_q   <= fill_q + 1'b1;
      primed_q <= (fill_q == (FILL_MAX - 1'b1));
    end
  end

  assign bus.out_valid  = valid_q[ROWS-1];
  assign bus.fill_count = fill_q;
  assign bus.primed     = primed_q;

endmodule

// File: tb/tb_systolic_grid.sv
// Directed bench for systolic_grid: a pass-mode and an accumulate-mode grid
// share one stimulus stream; every expected value is hand-computed.
module tb_systolic_grid;
  import systolic_pkg::*;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int W    = 8;

  logic              clock;
  logic              reset;
  logic              enable;
  logic              clear;
  logic              set;
  logic              in_valid;
  logic [COLS*W-1:0] a_in;
  logic [COLS*W-1:0] b_in;

  int checks;
  int failures;

  systolic_if #(.ROWS(ROWS), .COLS(COLS), .W(W)) bus0 ();
  systolic_if #(.ROWS(ROWS), .COLS(COLS), .W(W)) bus1 ();

  assign bus0.enable   = enable;
  assign bus0.clear    = clear;
  assign bus0.set      = set;
  assign bus0.in_valid = in_valid;
  assign bus0.a_in     = a_in;
  assign bus0.b_in     = b_in;
  assign bus1.enable   = enable;
  assign bus1.clear    = clear;
  assign bus1.set      = set;
  assign bus1.in_valid = in_valid;
  assign bus1.a_in     = a_in;
  assign bus1.b_in     = b_in;

  systolic_grid #(.ROWS(ROWS), .COLS(COLS), .W(W), .ACC_MODE(ACC_PASS)) dut_pass (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  systolic_grid #(.ROWS(ROWS), .COLS(COLS), .W(W), .ACC_MODE(ACC_SAT)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic st, input logic vld,
                       input logic [COLS*W-1:0] a, input logic [COLS*W-1:0] b);
    enable   = en;
    clear    = clr;
    set      = st;
    in_valid = vld;
    a_in     = a;
    b_in     = b;
  endtask

  function automatic logic [W-1:0] lane(input logic [COLS*W-1:0] v, input int c);
    return v[c*W +: W];
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(2);

    check("rst_a_out",      bus0.a_out,      0);
    check("rst_b_out",      bus0.b_out,      0);
    check("rst_out_valid",  bus0.out_valid,  0);
    check("rst_fill",       bus0.fill_count, 0);
    check("rst_primed",     bus0.primed,     0);
    reset = 1'b0;

    // Pass latency: one beat, then zeros.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 40'h00_00_3C_00_00, 40'h00_00_00_00_A5);
    step(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(3);
    check("lat_fill4",      bus0.fill_count, 4);
    check("lat_primed4",    bus0.primed,     0);
    check("lat_valid4",     bus0.out_valid,  0);
    step(1);
    check("lat_a_lane2",    lane(bus0.a_out, 2), 8'h3C);
    check("lat_b_lane4",    lane(bus0.b_out, 4), 8'hA5);
    check("lat_valid5",     bus0.out_valid,  1);
    check("lat_fill5",      bus0.fill_count, 5);
    check("lat_primed5",    bus0.primed,     1);
    step(1);
    check("lat_valid6",     bus0.out_valid,  0);
    check("lat_a6",         bus0.a_out,      0);

    // Stall: 3 enabled, 3 stalled, 2 enabled edges.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1);
    check("clr_fill",       bus0.fill_count, 0);
    check("clr_primed",     bus0.primed,     0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 40'h00_00_3C_00_00, 40'h00_00_00_00_A5);
    step(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(2);
    enable = 1'b0;
    step(3);
    check("stall_fill_hold", bus0.fill_count, 3);
    check("stall_valid",     bus0.out_valid,  0);
    enable = 1'b1;
    step(1);
    check("stall_fill4",    bus0.fill_count, 4);
    check("stall_primed4",  bus0.primed,     0);
    check("stall_valid7",   bus0.out_valid,  0);
    step(1);
    check("stall_a_lane2",  lane(bus0.a_out, 2), 8'h3C);
    check("stall_b_lane4",  lane(bus0.b_out, 4), 8'hA5);
    check("stall_valid8",   bus0.out_valid,  1);
    check("stall_fill5",    bus0.fill_count, 5);
    check("stall_primed5",  bus0.primed,     1);
    step(1);
    check("fill_saturate",  bus0.fill_count, 5);
    check("primed_hold",    bus0.primed,     1);

    // Saturating accumulate on the ACC_SAT grid.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 40'h08_08_08_08_08, 40'h00_00_00_00_F0);
    step(5);
    check("sat_b_lane4",    lane(bus1.b_out, 4), 8'hFF);
    check("pass_b_lane4",   lane(bus0.b_out, 4), 8'hF0);
    step(3);
    check("sat_no_wrap",    lane(bus1.b_out, 4), 8'hFF);
    a_in = 40'h01_01_01_01_01;
    step(5);
    check("acc_b_lane4",    lane(bus1.b_out, 4), 8'hF5);
    check("acc_b_lane0",    lane(bus1.b_out, 0), 8'h01);

    // clear + set + enable together: b and count clear, a still advances.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 40'h11_22_33_44_55, '0);
    step(1);
    check("prio_b_pass",    bus0.b_out,      0);
    check("prio_b_sat",     bus1.b_out,      0);
    check("prio_fill",      bus0.fill_count, 0);
    check("prio_valid",     bus0.out_valid,  0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(4);
    check("prio_a_advanced", bus0.a_out,      40'h11_22_33_44_55);
    check("prio_fill4",      bus0.fill_count, 4);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    step(1);
    check("set_b_pass",     bus0.b_out,      40'hFF_FF_FF_FF_FF);
    check("set_b_sat",      bus1.b_out,      40'hFF_FF_FF_FF_FF);
    check("set_a_hold",     bus0.a_out,      40'h11_22_33_44_55);
    check("set_fill_hold",  bus0.fill_count, 4);

    // Edge column: only lane 0 of b_in is nonzero.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 40'hAA_BB_CC_DD_EE, 40'h00_00_00_00_11);
    step(5);
    check("edge_b_out",     bus0.b_out,      40'h11_00_00_00_00);
    check("edge_b_lane0",   lane(bus0.b_out, 0), 8'h00);
    check("edge_a_out",     bus0.a_out,      40'hAA_BB_CC_DD_EE);
    check("edge_valid",     bus0.out_valid,  1);
    check("edge_primed",    bus0.primed,     1);

    // Asynchronous reset mid-stream, checked before the next clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("async_a_out",    bus0.a_out,      0);
    check("async_b_out",    bus0.b_out,      0);
    check("async_b_sat",    bus1.b_out,      0);
    check("async_valid",    bus0.out_valid,  0);
    check("async_fill",     bus0.fill_count, 0);
    check("async_primed",   bus0.primed,     0);
    #2;
    reset = 1'b0;
    step(1);
    check("restart_fill",   bus0.fill_count, 1);
    check("restart_primed", bus0.primed,     0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
